bus_req_queue: RTL and testbench

Per-processor request staging queue sitting directly upstream of the snooping bus interconnect. Accepts cache-transfer requests (bus request type, address, source, destination) one per cycle from the cache side, buffers them in one FIFO per processor, and presents each FIFO head to the bus as `request[i]` / `request_dest[i]`, holding it until the bus grants that processor. Tracks per-processor occupancy and flags heads that starve on the bus.

---
 rtl/bus_req_queue_if.sv | 42 ++++
 rtl/bus_req_queue.sv | 109 ++++++++++
 tb/tb_bus_req_queue.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_req_queue_if.sv
// Cache-side enqueue and bus-side request/grant bundle
// for the per-processor bus request queue.
interface bus_req_queue_if #(
  parameter int NUM_PROC = 4,
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 64,
  parameter int BRT_W    = 32
);
  localparam int PROC_W = $clog2(NUM_PROC);
  localparam int DEST_W = $clog2(NUM_PROC) + 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic                             enq_valid;
  logic [PROC_W-1:0]                enq_proc;
  logic [DEST_W-1:0]                enq_dest;
  logic [BRT_W-1:0]                 enq_brt;
  logic [ADDR_W-1:0]                enq_addr;
  logic                             enq_ready;
  logic [NUM_PROC-1:0]              request;
  logic [NUM_PROC-1:0][DEST_W-1:0]  request_dest;
  logic [NUM_PROC-1:0][BRT_W-1:0]   request_brt;
  logic [NUM_PROC-1:0][ADDR_W-1:0]  request_addr;
  logic [NUM_PROC-1:0]              grant;
  logic [NUM_PROC-1:0][CNT_W-1:0]   occupancy;
  logic [NUM_PROC-1:0]              stall_err;

  modport master (
    output enq_valid, enq_proc, enq_dest,
    output enq_brt, enq_addr, grant,
    input  enq_ready, request, request_dest,
    input  request_brt, request_addr,
    input  occupancy, stall_err
  );

  modport slave (
    input  enq_valid, enq_proc, enq_dest,
    input  enq_brt, enq_addr, grant,
    output enq_ready, request, request_dest,
    output request_brt, request_addr,
    output occupancy, stall_err
  );
endinterface

// File: rtl/bus_req_queue.sv
// Per-processor request FIFOs feeding the snooping bus;
// heads held until granted, starving heads flagged.
module bus_req_queue #(
  parameter int NUM_PROC    = 4,
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = 64,
  parameter int BRT_W       = 32,
  parameter int STALL_LIMIT = 1024
) (
  input logic            clk,
  input logic            rst_l,
  bus_req_queue_if.slave bus
);
  localparam int PROC_W = $clog2(NUM_PROC);
  localparam int DEST_W = $clog2(NUM_PROC) + 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int WAIT_W = $clog2(STALL_LIMIT + 1);

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [BRT_W-1:0]  brt;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  entry_t                           mem [NUM_PROC][DEPTH];
  logic [NUM_PROC-1:0][PTR_W-1:0]   wr_ptr;
  logic [NUM_PROC-1:0][PTR_W-1:0]   rd_ptr;
  logic [NUM_PROC-1:0][CNT_W-1:0]   cnt;
  logic [NUM_PROC-1:0][WAIT_W-1:0]  wait_cnt;
  logic [NUM_PROC-1:0][WAIT_W-1:0]  wait_nxt;
  logic [NUM_PROC-1:0]              err;
  logic [NUM_PROC-1:0]              nonempty;
  logic [NUM_PROC-1:0]              full;
  logic [NUM_PROC-1:0]              push;
  logic [NUM_PROC-1:0]              pop;
  logic                             rdy;
  entry_t                           wr_entry;

  // Per-FIFO status, push/pop strobes, head outputs
  always_comb begin
    rdy      = 1'b0;
    nonempty = '0;
    full     = '0;
    push     = '0;
    pop      = '0;
    wait_nxt = wait_cnt;
    wr_entry = '{dest: bus.enq_dest,
                 brt:  bus.enq_brt,
                 addr: bus.enq_addr};
    bus.request_dest = '0;
    bus.request_brt  = '0;
    bus.request_addr = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      nonempty[i] = cnt[i] != '0;
      full[i]     = cnt[i] == CNT_W'(DEPTH);
    end
    // A full FIFO refuses even if it pops this cycle
    rdy = !full[bus.enq_proc];
    for (int i = 0; i < NUM_PROC; i++) begin
      pop[i]  = bus.grant[i] && nonempty[i];
      push[i] = bus.enq_valid && rdy &&
                (bus.enq_proc == PROC_W'(i));
      if (!nonempty[i] || pop[i])
        wait_nxt[i] = '0;
      else if (wait_cnt[i] != WAIT_W'(STALL_LIMIT))
        wait_nxt[i] = wait_cnt[i] + WAIT_W'(1);
      if (nonempty[i]) begin
        bus.request_dest[i] = mem[i][rd_ptr[i]].dest;
        bus.request_brt[i]  = mem[i][rd_ptr[i]].brt;
        bus.request_addr[i] = mem[i][rd_ptr[i]].addr;
      end
    end
  end

  assign bus.enq_ready = rdy;
  assign bus.request   = nonempty;
  assign bus.occupancy = cnt;
  assign bus.stall_err = err;

  // Entry storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PROC; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= wr_entry;
  end

  // Pointers, counts, head-wait and sticky stall flags
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      wait_cnt <= '0;
      err      <= '0;
    end else begin
      for (int i = 0; i < NUM_PROC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        if (push[i] && !pop[i])
          cnt[i] <= cnt[i] + CNT_W'(1);
        else if (!push[i] && pop[i])
          cnt[i] <= cnt[i] - CNT_W'(1);
        wait_cnt[i] <= wait_nxt[i];
        if (wait_nxt[i] == WAIT_W'(STALL_LIMIT))
          err[i] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bus_req_queue.sv
// Directed plus randomized bench for bus_req_queue
// against a queue-based reference model.
module tb_bus_req_queue;
  localparam int NP = 4;
  localparam int DP = 4;
  localparam int AW = 64;
  localparam int BW = 32;
  localparam int SL = 8;
  localparam int DW = $clog2(NP) + 1;

  typedef struct {
    logic [DW-1:0] dest;
    logic [BW-1:0] brt;
    logic [AW-1:0] addr;
  } ent_t;

  logic clk = 1'b0;
  logic rst_l;
  int   checks = 0;
  int   errors = 0;

  ent_t q [NP][$];
  int   wt [NP];
  bit   se [NP];

  bus_req_queue_if #(
    .NUM_PROC(NP), .DEPTH(DP),
    .ADDR_W(AW), .BRT_W(BW)
  ) bus ();

  bus_req_queue #(
    .NUM_PROC(NP), .DEPTH(DP), .ADDR_W(AW),
    .BRT_W(BW), .STALL_LIMIT(SL)
  ) dut (
    .clk(clk),
    .rst_l(rst_l),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(bit v, int p, logic [DW-1:0] d,
                       logic [BW-1:0] b, logic [AW-1:0] a,
                       logic [NP-1:0] g);
    bus.enq_valid = v;
    bus.enq_proc  = 2'(p);
    bus.enq_dest  = d;
    bus.enq_brt   = b;
    bus.enq_addr  = a;
    bus.grant     = g;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      q[i].delete();
      wt[i] = 0;
      se[i] = 0;
    end
  endtask

  // Apply one clock of the queue rules to the model
  task automatic model_step();
    int   p;
    bit   room;
    bit   popd;
    ent_t e;
    p    = int'(bus.enq_proc);
    room = q[p].size() < DP;
    for (int i = 0; i < NP; i++) begin
      popd = bus.grant[i] && (q[i].size() > 0);
      if (q[i].size() == 0 || popd) wt[i] = 0;
      else if (wt[i] < SL) wt[i]++;
      if (wt[i] == SL) se[i] = 1;
      if (popd) void'(q[i].pop_front());
    end
    if (bus.enq_valid && room) begin
      e.dest = bus.enq_dest;
      e.brt  = bus.enq_brt;
      e.addr = bus.enq_addr;
      q[p].push_back(e);
    end
  endtask

  task automatic check_all();
    bit has;
    for (int i = 0; i < NP; i++) begin
      has = q[i].size() > 0;
      chk($sformatf("request[%0d]", i),
          64'(bus.request[i]), 64'(has));
      chk($sformatf("dest[%0d]", i),
          64'(bus.request_dest[i]),
          has ? 64'(q[i][0].dest) : 64'd0);
      chk($sformatf("brt[%0d]", i),
          64'(bus.request_brt[i]),
          has ? 64'(q[i][0].brt) : 64'd0);
      chk($sformatf("addr[%0d]", i),
          bus.request_addr[i],
          has ? q[i][0].addr : 64'd0);
      chk($sformatf("occupancy[%0d]", i),
          64'(bus.occupancy[i]), 64'(q[i].size()));
      chk($sformatf("stall_err[%0d]", i),
          64'(bus.stall_err[i]), 64'(se[i]));
    end
  endtask

  // Inputs are driven at posedge+1; sample before and after edge
  task automatic tick();
    #1;
    chk("enq_ready", 64'(bus.enq_ready),
        64'(q[int'(bus.enq_proc)].size() < DP));
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, '0, '0);
  endtask

  initial begin
    logic [AW-1:0] a;
    model_reset();
    idle();
    rst_l = 1'b0;
    #23;
    check_all();
    chk("reset enq_ready", 64'(bus.enq_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_l = 1'b1;

    drive(1, 2, 3'd1, 32'd3, 64'h1000, '0);
    tick();
    chk("t1 request", 64'(bus.request), 64'b0100);
    chk("t1 dest", 64'(bus.request_dest[2]), 64'd1);
    chk("t1 addr", bus.request_addr[2], 64'h1000);
    chk("t1 occ", 64'(bus.occupancy[2]), 64'd1);

    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 3'(k), 32'(k), 64'(16 * (k + 1)),
            k == 0 ? 4'b0100 : 4'b0000);
      tick();
    end
    drive(1, 0, 3'd7, 32'd7, 64'h50, '0);
    #1;
    chk("t2 full ready", 64'(bus.enq_ready), 64'd0);
    tick();
    chk("t2 occ full", 64'(bus.occupancy[0]), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk("t2 head", bus.request_addr[0],
          64'(16 * (k + 1)));
      drive(0, 0, '0, '0, '0, 4'b0001);
      tick();
    end
    chk("t2 drained", 64'(bus.request[0]), 64'd0);
    chk("t2 occ 0", 64'(bus.occupancy[0]), 64'd0);

    drive(1, 1, 3'd2, 32'd1, 64'h100, '0);
    tick();
    drive(1, 1, 3'd2, 32'd1, 64'h200, '0);
    tick();
    drive(1, 1, 3'd2, 32'd1, 64'h300, 4'b0010);
    tick();
    chk("t3 occ", 64'(bus.occupancy[1]), 64'd2);
    chk("t3 head", bus.request_addr[1], 64'h200);
    for (int k = 0; k < 10; k++) begin
      a = {$urandom, $urandom};
      drive(1, 1, 3'($urandom), $urandom, a, 4'b0010);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, '0, '0, '0, 4'b0010);
      tick();
    end

    drive(1, 3, 3'd0, 32'd9, 64'hABC, '0);
    tick();
    drive(0, 0, '0, '0, '0, 4'b1111);
    tick();
    chk("t4 request", 64'(bus.request), 64'd0);

    for (int k = 0; k < 4; k++) begin
      drive(1, 3, 3'd1, 32'(k), 64'(k + 32'h300), '0);
      tick();
    end
    drive(1, 3, 3'd1, 32'd9, 64'h999, 4'b1000);
    tick();
    chk("t6 occ", 64'(bus.occupancy[3]), 64'd3);

    idle();
    rst_l = 1'b0;
    #2;
    model_reset();
    rst_l = 1'b1;
    drive(1, 2, 3'd3, 32'd5, 64'h2000, '0);
    tick();
    for (int k = 1; k <= SL; k++) begin
      idle();
      tick();
      if (k == SL - 1)
        chk("t5 no err yet", 64'(bus.stall_err[2]), 64'd0);
    end
    chk("t5 stall", 64'(bus.stall_err[2]), 64'd1);
    drive(0, 0, '0, '0, '0, 4'b0100);
    tick();
    chk("t5 sticky", 64'(bus.stall_err[2]), 64'd1);
    drive(1, 2, 3'd3, 32'd5, 64'h2100, '0);
    tick();
    drive(1, 1, 3'd3, 32'd5, 64'h2200, '0);
    tick();
    rst_l = 1'b0;
    #2;
    model_reset();
    chk("t5 rst request", 64'(bus.request), 64'd0);
    chk("t5 rst err", 64'(bus.stall_err), 64'd0);
    chk("t5 rst occ", 64'(bus.occupancy), 64'd0);
    check_all();
    #1;
    rst_l = 1'b1;
    idle();

    for (int k = 0; k < 400; k++) begin
      a = {$urandom, $urandom};
      drive($urandom_range(0, 3) != 0,
            int'($urandom_range(0, NP - 1)),
            3'($urandom), $urandom, a,
            4'($urandom & $urandom));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
